// File: rtl/set_job_dispatcher.sv
// Job dispatcher for the circle-set counting core: queues jobs, launches them one at a time,
// captures the core's count (or a watchdog timeout) and returns it with the job tag.
module set_job_dispatcher #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [23:0]      job_central,
  input  logic [11:0]      job_radius,
  input  logic [1:0]       job_mode,
  input  logic [TAG_W-1:0] job_tag,
  output logic             core_en,
  output logic [23:0]      core_central,
  output logic [11:0]      core_radius,
  output logic [1:0]       core_mode,
  input  logic             core_busy,
  input  logic             core_valid,
  input  logic [7:0]       core_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             res_range_err,
  output logic             idle,
  output logic [15:0]      done_count
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned JOB_W     = 24 + 12 + 2 + TAG_W;
  localparam int unsigned TMR_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned RANGE_MAX = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_RESULT, S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [JOB_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, push, pop;

  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  logic [23:0]      central_q, central_d;
  logic [11:0]      radius_q, radius_d;
  logic [1:0]       mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       res_cand_q, res_cand_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_to_q, res_to_d;
  logic             res_re_q, res_re_d;
  logic [15:0]      done_q, done_d;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign timer_inc = timer_q + TMR_W'(1);

  // Job storage; only the pointers and count need reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {job_central, job_radius, job_mode, job_tag};
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    central_d  = central_q;
    radius_d   = radius_q;
    mode_d     = mode_q;
    tag_d      = tag_q;
    res_cand_d = res_cand_q;
    res_tag_d  = res_tag_q;
    res_to_d   = res_to_q;
    res_re_d   = res_re_q;
    done_d     = done_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          {central_d, radius_d, mode_d, tag_d} = mem_q[rd_ptr_q];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A real result beats a watchdog expiry in the same cycle
        if (core_valid) begin
          res_cand_d = core_candidate;
          res_to_d   = 1'b0;
          res_re_d   = (core_candidate > 8'(RANGE_MAX));
          res_tag_d  = tag_q;
          state_d    = S_RESULT;
        end else if (timer_inc == TMR_W'(TIMEOUT)) begin
          res_cand_d = '0;
          res_to_d   = 1'b1;
          res_re_d   = 1'b0;
          res_tag_d  = tag_q;
          state_d    = S_RESULT;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          done_d  = done_q + 16'd1;
          timer_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!core_busy || (timer_inc == TMR_W'(TIMEOUT))) state_d = S_IDLE;
        else timer_d = timer_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      central_q  <= '0;
      radius_q   <= '0;
      mode_q     <= '0;
      tag_q      <= '0;
      res_cand_q <= '0;
      res_tag_q  <= '0;
      res_to_q   <= 1'b0;
      res_re_q   <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      central_q  <= central_d;
      radius_q   <= radius_d;
      mode_q     <= mode_d;
      tag_q      <= tag_d;
      res_cand_q <= res_cand_d;
      res_tag_q  <= res_tag_d;
      res_to_q   <= res_to_d;
      res_re_q   <= res_re_d;
      done_q     <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  assign core_en       = (state_q == S_LAUNCH);
  assign res_valid     = (state_q == S_RESULT);
  assign idle          = (state_q == S_IDLE) && empty;
  assign core_central  = central_q;
  assign core_radius   = radius_q;
  assign core_mode     = mode_q;
  assign res_candidate = res_cand_q;
  assign res_tag       = res_tag_q;
  assign res_timeout   = res_to_q;
  assign res_range_err = res_re_q;
  assign done_count    = done_q;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Self-checking bench for set_job_dispatcher: table of jobs with expected results, a behavioural
// core model, and a scoreboard queue checked at every result handshake.
module tb_set_job_dispatcher;

  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic job_ready;
  logic [23:0] job_central = '0;
  logic [11:0] job_radius = '0;
  logic [1:0] job_mode = '0;
  logic [TAG_W-1:0] job_tag = '0;
  logic core_en;
  logic [23:0] core_central;
  logic [11:0] core_radius;
  logic [1:0] core_mode;
  logic core_busy, core_valid;
  logic [7:0] core_candidate;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [7:0] res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic res_timeout, res_range_err, idle;
  logic [15:0] done_count;

  logic m_busy = 1'b0, m_valid = 1'b0, stray_valid = 1'b0;
  logic [7:0] m_cand = '0, stray_cand = '0;
  int m_left = 0;
  bit m_hang = 1'b0;

  assign core_busy      = m_busy;
  assign core_valid     = m_valid | stray_valid;
  assign core_candidate = m_valid ? m_cand : stray_cand;

  always #5 clk = ~clk;

  set_job_dispatcher dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode), .job_tag(job_tag),
    .core_en(core_en), .core_central(core_central), .core_radius(core_radius), .core_mode(core_mode),
    .core_busy(core_busy), .core_valid(core_valid), .core_candidate(core_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate), .res_tag(res_tag),
    .res_timeout(res_timeout), .res_range_err(res_range_err), .idle(idle), .done_count(done_count)
  );

  typedef struct {
    logic [23:0] central; logic [11:0] radius; logic [1:0] mode; logic [3:0] tag;
    logic [7:0] cand; bit hang; int busy_len;
    logic [7:0] exp_cand; bit exp_to; bit exp_re;
  } vec_t;
  typedef struct { logic [37:0] ops; logic [7:0] cand; bit hang; int busy_len; } core_job_t;
  typedef struct { logic [7:0] cand; logic [3:0] tag; bit to; bit re; } exp_t;

  vec_t vecs [18];
  core_job_t core_q[$];
  exp_t exp_q[$];
  exp_t e_m;
  core_job_t j_m;
  logic [37:0] op_lat = '0;

  int checks = 0, passes = 0;
  int cyc = 0, en_count = 0, last_en = -100, hs_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Core model plus result/launch monitor, all on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
    end else begin
      if (res_valid && res_ready) begin
        hs_count++;
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          e_m = exp_q.pop_front();
          check("res_candidate", res_candidate, e_m.cand);
          check("res_tag", res_tag, e_m.tag);
          check("res_timeout", res_timeout, e_m.to);
          check("res_range_err", res_range_err, e_m.re);
          check("ops_stable_at_result", {core_central, core_radius, core_mode}, op_lat);
        end
      end
      m_valid = 1'b0;
      if (core_en) begin
        en_count++;
        check("en_spacing", (cyc - last_en) >= 5, 1);
        check("en_while_busy", m_busy, 0);
        last_en = cyc;
        op_lat = {core_central, core_radius, core_mode};
        if (core_q.size() == 0) check("launch_without_job", 1, 0);
        else begin
          j_m = core_q.pop_front();
          check("launch_operands", op_lat, j_m.ops);
          m_busy = 1'b1; m_left = j_m.busy_len; m_cand = j_m.cand; m_hang = j_m.hang;
        end
      end else if (m_busy) begin
        m_left--;
        if (m_left <= 0) begin
          m_busy = 1'b0;
          if (!m_hang) m_valid = 1'b1;
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the job is accepted
  task automatic push_job(input vec_t v);
    int n = 0;
    core_job_t cj;
    exp_t ex;
    cj.ops = {v.central, v.radius, v.mode}; cj.cand = v.cand; cj.hang = v.hang; cj.busy_len = v.busy_len;
    ex.cand = v.exp_cand; ex.tag = v.tag; ex.to = v.exp_to; ex.re = v.exp_re;
    core_q.push_back(cj);
    exp_q.push_back(ex);
    job_central = v.central; job_radius = v.radius; job_mode = v.mode; job_tag = v.tag;
    job_valid = 1'b1;
    while (!job_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!job_ready) check("job_accept_timeout", 0, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n = 0;
    while (hs_count < target && n < budget) begin @(posedge clk); #1; n++; end
    check(name, hs_count >= target, 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic vec_t mk(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                              input logic [3:0] t, input logic [7:0] cand, input bit hang,
                              input int bl, input logic [7:0] ec, input bit eto, input bit ere);
    vec_t v;
    v.central = c; v.radius = r; v.mode = m; v.tag = t; v.cand = cand; v.hang = hang;
    v.busy_len = bl; v.exp_cand = ec; v.exp_to = eto; v.exp_re = ere;
    return v;
  endfunction

  initial begin
    int en0, n, delta, base_hs;
    bit stable, seen;
    logic [15:0] snap;

    vecs[0]  = mk(24'h440000, 12'h200, 2'd0, 4'd3, 8'd13, 0, 64, 8'd13, 0, 0);
    vecs[1]  = mk(24'h123456, 12'h111, 2'd1, 4'd0, 8'd20, 0, 20, 8'd20, 0, 0);
    vecs[2]  = mk(24'h654321, 12'h222, 2'd2, 4'd1, 8'd33, 0, 20, 8'd33, 0, 0);
    vecs[3]  = mk(24'hABCDEF, 12'h333, 2'd3, 4'd2, 8'd64, 0, 20, 8'd64, 0, 0);
    vecs[4]  = mk(24'h0F0F0F, 12'h444, 2'd0, 4'd3, 8'd7,  0, 20, 8'd7,  0, 0);
    vecs[5]  = mk(24'hF0F0F0, 12'h555, 2'd1, 4'd4, 8'd0,  0, 20, 8'd0,  0, 0);
    vecs[6]  = mk(24'h111111, 12'h666, 2'd2, 4'd8, 8'd65, 0, 30, 8'd65, 0, 1);
    vecs[7]  = mk(24'h222222, 12'h777, 2'd3, 4'd9, 8'd200, 0, 30, 8'd200, 0, 1);
    vecs[8]  = mk(24'h333333, 12'h888, 2'd0, 4'hA, 8'd5,  0, 10, 8'd5,  0, 0);
    vecs[9]  = mk(24'h444444, 12'h999, 2'd1, 4'hB, 8'd6,  0, 10, 8'd6,  0, 0);
    vecs[10] = mk(24'h555555, 12'hAAA, 2'd2, 4'hC, 8'd7,  0, 10, 8'd7,  0, 0);
    vecs[11] = mk(24'h666666, 12'hBBB, 2'd3, 4'd1, 8'd99, 1, 100, 8'd0, 1, 0);
    vecs[12] = mk(24'h777777, 12'hCCC, 2'd0, 4'd2, 8'd99, 1, 450, 8'd0, 1, 0);
    vecs[13] = mk(24'h888888, 12'hDDD, 2'd1, 4'd5, 8'd42, 0, 30, 8'd42, 0, 0);
    vecs[14] = mk(24'h999999, 12'hEEE, 2'd2, 4'd6, 8'd1,  0, 64, 8'd1,  0, 0);
    vecs[15] = mk(24'hAAAAAA, 12'hFFF, 2'd3, 4'd7, 8'd2,  0, 64, 8'd2,  0, 0);
    vecs[16] = mk(24'hBBBBBB, 12'h123, 2'd0, 4'd8, 8'd3,  0, 64, 8'd3,  0, 0);
    vecs[17] = mk(24'hCCCCCC, 12'h321, 2'd1, 4'hF, 8'd11, 0, 20, 8'd11, 0, 0);

    // Reset state
    step(3);
    check("rst_core_en", core_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_outputs", {core_central, core_radius, core_mode, res_candidate, res_tag,
                          res_timeout, res_range_err}, 0);
    check("rst_done_count", done_count, 0);
    check("rst_idle", idle, 1);
    check("rst_job_ready", job_ready, 1);
    rst = 1'b0;
    res_ready = 1'b1;
    step(2);
    check("no_en_after_rst", en_count, 0);

    // Single job: result must rise the cycle after the core strobe
    push_job(vecs[0]);
    n = 0; seen = 0;
    while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("t1_res_valid_seen", res_valid, 1);
    check("t1_res_after_strobe", core_valid, 1);
    wait_hs(1, 50, "t1_handshake");
    step(3);
    check("t1_one_en", en_count, 1);
    check("t1_done_count", done_count, 1);

    // Back-to-back jobs through a full FIFO
    for (int i = 1; i <= 5; i++) push_job(vecs[i]);
    check("t2_fifo_full", job_ready, 0);
    wait_hs(6, 1000, "t2_all_results");
    step(3);
    check("t2_done_count", done_count, 6);
    check("t2_en_count", en_count, 6);

    // Backpressure: result held while more jobs are queued
    res_ready = 1'b0;
    push_job(vecs[8]);
    n = 0;
    while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("t3_res_valid", res_valid, 1);
    snap = {res_candidate, res_tag, res_timeout, res_range_err, 2'b00};
    en0 = en_count;
    push_job(vecs[9]);
    push_job(vecs[10]);
    stable = 1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (!res_valid || {res_candidate, res_tag, res_timeout, res_range_err, 2'b00} != snap) stable = 0;
    end
    check("t3_res_stable", stable, 1);
    check("t3_no_en_while_held", en_count, en0);
    check("t3_held_cand", res_candidate, 8'd5);
    res_ready = 1'b1;
    wait_hs(9, 300, "t3_results");
    step(3);
    check("t3_done_count", done_count, 9);

    // Hung core, busy drops during WAIT
    push_job(vecs[11]);
    n = 0;
    while (!res_valid && n < 400) begin @(posedge clk); #1; n++; end
    delta = cyc - last_en;
    check("t4_timeout_seen", res_valid, 1);
    check("t4_wait_length_ok", (delta >= 198) && (delta <= 203), 1);
    wait_hs(10, 20, "t4_hang_result");
    // Hung core with busy stuck: DRAIN must force its way out
    base_hs = hs_count;
    push_job(vecs[12]);
    wait_hs(11, 400, "t4_stuck_result");
    n = 0;
    while (!idle && n < 300) begin @(posedge clk); #1; n++; end
    check("t4_forced_drain_exit", {idle, core_busy}, 2'b11);
    n = 0;
    while (core_busy && n < 200) begin @(posedge clk); #1; n++; end
    push_job(vecs[13]);
    wait_hs(12, 200, "t4_relaunch_result");
    step(3);
    check("t4_done_count", done_count, 12);

    // Out-of-range counts, then a stray strobe while idle
    for (int i = 6; i <= 7; i++) push_job(vecs[i]);
    wait_hs(14, 300, "t5_results");
    n = 0;
    while (!idle && n < 50) begin @(posedge clk); #1; n++; end
    stray_cand = 8'h30; stray_valid = 1'b1;
    step(1);
    stray_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(1); if (res_valid) seen = 1; end
    check("t5_stray_ignored", seen, 0);
    check("t5_idle", idle, 1);
    check("t5_done_count", done_count, 14);

    // Reset mid-WAIT with two jobs queued
    en0 = en_count;
    for (int i = 14; i <= 16; i++) push_job(vecs[i]);
    n = 0;
    while (en_count == en0 && n < 50) begin @(posedge clk); #1; n++; end
    step(10);
    rst = 1'b1;
    #1;
    core_q.delete();
    exp_q.delete();
    check("t6_rst_outputs", {core_en, res_valid, core_central, core_radius, core_mode, res_candidate,
                             res_tag, res_timeout, res_range_err}, 0);
    check("t6_rst_done", done_count, 0);
    check("t6_rst_idle_ready", {idle, job_ready}, 2'b11);
    step(2);
    rst = 1'b0;
    en0 = en_count;
    step(20);
    check("t6_no_en_after_rst", en_count, en0);
    check("t6_idle", idle, 1);
    base_hs = hs_count;
    push_job(vecs[17]);
    wait_hs(base_hs + 1, 200, "t6_new_result");
    step(3);
    check("t6_done_restart", done_count, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
